// File: rtl/pixel_src_if.sv
// Pixel-source bundle between the drawing FSMs, the arbiter and the VGA write port.
// master = environment (sources and VGA sink), slave = arbiter.
interface pixel_src_if #(
  parameter int NUM_SRC = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]     src_valid;
  logic [NUM_SRC-1:0]     src_ready;
  logic [NUM_SRC*X_W-1:0] src_x;
  logic [NUM_SRC*Y_W-1:0] src_y;
  logic [NUM_SRC*C_W-1:0] src_color;
  logic                   force_en;
  logic [SEL_W-1:0]       force_sel;
  logic [X_W-1:0]         out_x;
  logic [Y_W-1:0]         out_y;
  logic [C_W-1:0]         out_color;
  logic                   out_plot;
  logic                   out_ready;
  logic [SEL_W-1:0]       out_src;
  logic                   owner_change;

  modport master (
    output src_valid, src_x, src_y, src_color, force_en, force_sel, out_ready,
    input  src_ready, out_x, out_y, out_color, out_plot, out_src, owner_change
  );

  modport slave (
    input  src_valid, src_x, src_y, src_color, force_en, force_sel, out_ready,
    output src_ready, out_x, out_y, out_color, out_plot, out_src, owner_change
  );
endinterface

// File: rtl/pixel_source_arbiter.sv
// N-way pixel-write arbiter: fixed-priority or round-robin grant with burst lock
// and forced-source override, feeding one registered plot beat to the VGA adapter.
module pixel_source_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int C_W        = 3,
  parameter int MODE       = 0,
  parameter int LOCK_BEATS = 1
) (
  input logic        clock,
  input logic        reset,
  pixel_src_if.slave bus
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LCW   = $clog2(LOCK_BEATS + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_BEATS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

  logic [X_W-1:0]   out_x_q, out_x_d;
  logic [Y_W-1:0]   out_y_q, out_y_d;
  logic [C_W-1:0]   out_color_q, out_color_d;
  logic             out_plot_q, out_plot_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             owner_change_q, owner_change_d;
  logic [SEL_W-1:0] last_src_q, last_src_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic               load_en;
  logic [NUM_SRC-1:0] cand;
  logic               hold_own;
  logic [SEL_W-1:0]   grant;
  logic               grant_vld;
  logic [NUM_SRC-1:0] src_ready;
  int                 idx;

  // Grant selection. last_src doubles as the lock owner.
  always_comb begin
    load_en = !out_plot_q || bus.out_ready;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand[i] = bus.src_valid[i] && (!bus.force_en || int'(bus.force_sel) == i);
    end
    hold_own  = !bus.force_en && bus.src_valid[last_src_q] && (lock_cnt_q < LOCK_MAX);
    grant     = last_src_q;
    grant_vld = 1'b0;
    idx       = 0;
    if (hold_own) begin
      grant_vld = 1'b1;
    end else if (MODE == 0) begin
      // Descending scan so the lowest set index is the one left standing.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (cand[i]) begin
          grant     = SEL_W'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_SRC;
        if (cand[idx]) begin
          grant     = SEL_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (load_en && grant_vld) begin
      src_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    out_x_d        = out_x_q;
    out_y_d        = out_y_q;
    out_color_d    = out_color_q;
    out_plot_d     = out_plot_q;
    out_src_d      = out_src_q;
    owner_change_d = owner_change_q;
    last_src_d     = last_src_q;
    lock_cnt_d     = lock_cnt_q;
    rr_ptr_d       = rr_ptr_q;
    if (load_en && grant_vld) begin
      out_x_d        = bus.src_x[int'(grant)*X_W +: X_W];
      out_y_d        = bus.src_y[int'(grant)*Y_W +: Y_W];
      out_color_d    = bus.src_color[int'(grant)*C_W +: C_W];
      out_plot_d     = 1'b1;
      out_src_d      = grant;
      owner_change_d = (grant != last_src_q);
      last_src_d     = grant;
      rr_ptr_d       = grant;
      if (grant != last_src_q) begin
        lock_cnt_d = LCW'(1);
      end else if (lock_cnt_q != LOCK_MAX) begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end
    end else if (load_en) begin
      out_plot_d     = 1'b0;
      owner_change_d = 1'b0;
    end
  end

  // rr_ptr resets to the last index so source 0 is searched first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_x_q        <= '0;
      out_y_q        <= '0;
      out_color_q    <= '0;
      out_plot_q     <= 1'b0;
      out_src_q      <= '0;
      owner_change_q <= 1'b0;
      last_src_q     <= '0;
      lock_cnt_q     <= '0;
      rr_ptr_q       <= LAST_IDX;
    end else begin
      out_x_q        <= out_x_d;
      out_y_q        <= out_y_d;
      out_color_q    <= out_color_d;
      out_plot_q     <= out_plot_d;
      out_src_q      <= out_src_d;
      owner_change_q <= owner_change_d;
      last_src_q     <= last_src_d;
      lock_cnt_q     <= lock_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign bus.src_ready    = src_ready;
  assign bus.out_x        = out_x_q;
  assign bus.out_y        = out_y_q;
  assign bus.out_color    = out_color_q;
  assign bus.out_plot     = out_plot_q;
  assign bus.out_src      = out_src_q;
  assign bus.owner_change = owner_change_q;
endmodule

// File: tb/tb_pixel_source_arbiter.sv
// Scoreboard bench for pixel_source_arbiter: three instances cover fixed priority,
// round-robin, burst lock, force override, backpressure and asynchronous reset.
module tb_pixel_source_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pixel_src_if #(.NUM_SRC(4), .X_W(8), .Y_W(7), .C_W(3)) b0 ();
  pixel_src_if #(.NUM_SRC(4), .X_W(8), .Y_W(7), .C_W(3)) b1 ();
  pixel_src_if #(.NUM_SRC(3), .X_W(8), .Y_W(7), .C_W(3)) b2 ();

  pixel_source_arbiter #(.NUM_SRC(4), .X_W(8), .Y_W(7), .C_W(3), .MODE(0), .LOCK_BEATS(1))
    u0 (.clock(clk), .reset(rst), .bus(b0.slave));
  pixel_source_arbiter #(.NUM_SRC(4), .X_W(8), .Y_W(7), .C_W(3), .MODE(1), .LOCK_BEATS(1))
    u1 (.clock(clk), .reset(rst), .bus(b1.slave));
  pixel_source_arbiter #(.NUM_SRC(3), .X_W(8), .Y_W(7), .C_W(3), .MODE(1), .LOCK_BEATS(3))
    u2 (.clock(clk), .reset(rst), .bus(b2.slave));

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       oc;
  } beat_t;

  beat_t exp_q[3][$];
  int checks = 0;
  int failures = 0;

  function automatic beat_t mk(int s, int x, int y, int c, int oc);
    beat_t b;
    b.src = 2'(s);
    b.x   = 8'(x);
    b.y   = 7'(y);
    b.c   = 3'(c);
    b.oc  = 1'(oc);
    return b;
  endfunction

  // Default source payload: x = 16*(s+1), y = s+3, color = s+1.
  task automatic push(int d, int s, int oc);
    exp_q[d].push_back(mk(s, 16 * (s + 1), s + 3, s + 1, oc));
  endtask

  task automatic push_d(int d, int s, int x, int y, int c, int oc);
    exp_q[d].push_back(mk(s, x, y, c, oc));
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic check_beat(int d, beat_t got);
    beat_t e;
    checks++;
    if (exp_q[d].size() == 0) begin
      failures++;
      $display("FAIL beat_dut%0d: got src=%0d x=%0d y=%0d c=%0d oc=%0d, expected no beat (t=%0t)",
               d, got.src, got.x, got.y, got.c, got.oc, $time);
    end else begin
      e = exp_q[d].pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL beat_dut%0d: got src=%0d x=%0d y=%0d c=%0d oc=%0d, expected src=%0d x=%0d y=%0d c=%0d oc=%0d (t=%0t)",
                 d, got.src, got.x, got.y, got.c, got.oc, e.src, e.x, e.y, e.c, e.oc, $time);
      end
    end
  endtask

  // Monitor: a beat is compared when it retires (out_plot && out_ready).
  always @(negedge clk) begin
    if (!rst) begin
      if (b0.out_plot && b0.out_ready)
        check_beat(0, {b0.out_src, b0.out_x, b0.out_y, b0.out_color, b0.owner_change});
      if (b1.out_plot && b1.out_ready)
        check_beat(1, {b1.out_src, b1.out_x, b1.out_y, b1.out_color, b1.owner_change});
      if (b2.out_plot && b2.out_ready)
        check_beat(2, {b2.out_src, b2.out_x, b2.out_y, b2.out_color, b2.owner_change});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

  int          seq_b[5]  = '{0, 1, 2, 3, 0};
  logic [2:0]  val_c[8]  = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b111, 3'b111, 3'b111};
  int          src_c[8]  = '{0, 0, 0, 1, 2, 2, 2, 0};
  int          oc_c[8]   = '{0, 0, 0, 1, 1, 0, 0, 1};

  initial begin
    b0.src_valid = '0; b1.src_valid = '0; b2.src_valid = '0;
    b0.force_en = 1'b0; b1.force_en = 1'b0; b2.force_en = 1'b0;
    b0.force_sel = '0; b1.force_sel = '0; b2.force_sel = '0;
    b0.out_ready = 1'b1; b1.out_ready = 1'b1; b2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b0.src_x[i*8 +: 8] = 8'(16 * (i + 1)); b0.src_y[i*7 +: 7] = 7'(i + 3); b0.src_color[i*3 +: 3] = 3'(i + 1);
      b1.src_x[i*8 +: 8] = 8'(16 * (i + 1)); b1.src_y[i*7 +: 7] = 7'(i + 3); b1.src_color[i*3 +: 3] = 3'(i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      b2.src_x[i*8 +: 8] = 8'(16 * (i + 1)); b2.src_y[i*7 +: 7] = 7'(i + 3); b2.src_color[i*3 +: 3] = 3'(i + 1);
    end

    #1 rst = 1'b1;
    #2;
    chk("reset_plot0", 32'(b0.out_plot), 0);
    chk("reset_x0", 32'(b0.out_x), 0);
    chk("reset_src0", 32'(b0.out_src), 0);
    chk("reset_oc0", 32'(b0.owner_change), 0);
    chk("reset_ready0", 32'(b0.src_ready), 0);
    chk("reset_plot2", 32'(b2.out_plot), 0);
    #10 rst = 1'b0;
    tick();

    // Fixed priority: 1010 -> source 1 every cycle, source 3 starves.
    b0.src_valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      push(0, 1, (c == 0) ? 1 : 0);
      #1 chk("fixed_ready", 32'(b0.src_ready), 32'b0010);
      tick();
    end
    b0.src_valid = '0;
    tick();

    // Force to source 2 with everyone valid.
    b0.force_en = 1'b1; b0.force_sel = 2'd2; b0.src_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      push(0, 2, (c == 0) ? 1 : 0);
      #1 chk("force_ready", 32'(b0.src_ready), 32'b0100);
      tick();
    end
    b0.force_en = 1'b0; b0.src_valid = '0;
    tick();

    // Round-robin, all valid.
    b1.src_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      push(1, seq_b[c], (c > 0) ? 1 : 0);
      #1 chk("rr_ready", 32'(b1.src_ready), 32'(1) << seq_b[c]);
      tick();
    end
    b1.src_valid = '0;
    tick();

    // Backpressure: beat (159,119,5) held for 4 stalled cycles.
    b1.src_x[8 +: 8] = 8'd159; b1.src_y[7 +: 7] = 7'd119; b1.src_color[3 +: 3] = 3'b101;
    b1.src_valid = 4'b0010; b1.out_ready = 1'b0;
    push_d(1, 1, 159, 119, 5, 1);
    #1 chk("bp_load_ready", 32'(b1.src_ready), 32'b0010);
    tick();
    b1.src_x[8 +: 8] = 8'd10; b1.src_y[7 +: 7] = 7'd20; b1.src_color[3 +: 3] = 3'd3;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ready", 32'(b1.src_ready), 0);
      chk("bp_plot", 32'(b1.out_plot), 1);
      chk("bp_x", 32'(b1.out_x), 159);
      chk("bp_y", 32'(b1.out_y), 119);
      chk("bp_color", 32'(b1.out_color), 5);
      tick();
    end
    b1.out_ready = 1'b1;
    push_d(1, 1, 10, 20, 3, 0);
    #1 chk("bp_release_ready", 32'(b1.src_ready), 32'b0010);
    tick();
    chk("bp_nobubble_x", 32'(b1.out_x), 10);
    chk("bp_nobubble_plot", 32'(b1.out_plot), 1);
    b1.src_valid = '0;
    tick();
    b1.src_x[8 +: 8] = 8'd32; b1.src_y[7 +: 7] = 7'd4; b1.src_color[3 +: 3] = 3'd2;

    // Burst lock of 3 beats; source 1 drops after its first beat.
    for (int c = 0; c < 8; c++) begin
      b2.src_valid = val_c[c];
      push(2, src_c[c], oc_c[c]);
      #1 chk("lock_ready", 32'(b2.src_ready), 32'(1) << src_c[c]);
      tick();
    end
    b2.src_valid = '0;
    tick();

    // Force override, then an out-of-range force index grants nobody.
    b2.force_en = 1'b1; b2.force_sel = 2'd1; b2.src_valid = 3'b111;
    push(2, 1, 1);
    #1 chk("force2_ready", 32'(b2.src_ready), 32'b010);
    tick();
    b2.force_sel = 2'd3;
    #1;
    chk("force_oor_ready", 32'(b2.src_ready), 0);
    chk("force_oor_plot_before", 32'(b2.out_plot), 1);
    tick();
    chk("force_oor_plot_after", 32'(b2.out_plot), 0);
    chk("force_oor_ready2", 32'(b2.src_ready), 0);
    b2.force_en = 1'b0; b2.src_valid = '0;
    tick();

    // Reset mid-beat: in-flight beat from source 2 is dropped.
    b1.src_valid = 4'b0100;
    push(1, 2, 1);
    tick();
    b1.src_valid = '0; b1.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_plot", 32'(b1.out_plot), 0);
    chk("rst_x", 32'(b1.out_x), 0);
    chk("rst_y", 32'(b1.out_y), 0);
    chk("rst_color", 32'(b1.out_color), 0);
    chk("rst_src", 32'(b1.out_src), 0);
    chk("rst_oc", 32'(b1.owner_change), 0);
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    #3 rst = 1'b0;
    tick();
    b1.src_valid = 4'b1111; b1.out_ready = 1'b1;
    push(1, 0, 0);
    #1 chk("post_rst_ready", 32'(b1.src_ready), 32'b0001);
    tick();
    b1.src_valid = '0;
    tick();
    tick();

    for (int d = 0; d < 3; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        failures++;
        $display("FAIL drain_dut%0d: %0d expected beats never appeared, expected 0", d, exp_q[d].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
